// File: rtl/led_sr_if.sv
// Serial LED driver link: shift clock, data, latch strobe and frame-busy flag.
interface led_sr_if;
    logic sr_clk;
    logic sr_data;
    logic sr_latch;
    logic busy;

    modport master (output sr_clk, sr_data, sr_latch, busy);
    modport slave  (input  sr_clk, sr_data, sr_latch, busy);
endinterface

// File: rtl/led_status_controller.sv
// Stretches per-channel status events into LED on-times and mirrors the LED
// vector to an external shift-register driver, MSB first, with periodic refresh.
module led_status_controller #(
    parameter int N_CH           = 9,
    parameter int HOLD_CYCLES    = 8,
    parameter int CLK_DIV        = 2,
    parameter int REFRESH_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] event_in,
    input  logic            lamp_test,
    output logic [N_CH-1:0] led_out,
    led_sr_if.master        sr
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int REF_W = $clog2(REFRESH_CYCLES);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N_CH - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [15:0]      HOLD     = 16'(HOLD_CYCLES);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_SHIFT_LO = 2'd1;
    localparam logic [1:0] S_SHIFT_HI = 2'd2;
    localparam logic [1:0] S_LATCH    = 2'd3;

    logic [N_CH-1:0]       event_q;
    logic [N_CH-1:0]       rise;
    logic [N_CH-1:0][15:0] hold_q, hold_d;
    logic [N_CH-1:0]       led_state;
    logic [N_CH-1:0]       led_q;

    logic [1:0]            state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [REF_W-1:0]      ref_q, ref_d;
    logic [N_CH-1:0]       snap_q, snap_d;
    logic [N_CH-1:0]       shadow_q, shadow_d;
    logic                  sr_clk_q, sr_data_q, sr_latch_q, busy_q;
    logic                  div_last;

    // A rise reloads the counter outright, so retriggers extend rather than add.
    always_comb begin
        rise = event_in & ~event_q;
        for (int i = 0; i < N_CH; i++) begin
            if (rise[i])
                hold_d[i] = HOLD;
            else if (hold_q[i] != 16'd0)
                hold_d[i] = hold_q[i] - 16'd1;
            else
                hold_d[i] = hold_q[i];
            led_state[i] = (hold_q[i] != 16'd0) | lamp_test;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        idx_d    = idx_q;
        ref_d    = ref_q;
        snap_d   = snap_q;
        shadow_d = shadow_q;
        div_last = (div_q == DIV_LAST);
        case (state_q)
            S_IDLE: begin
                if ((led_q != shadow_q) || (ref_q == REF_LAST)) begin
                    state_d = S_SHIFT_LO;
                    snap_d  = led_q;
                    idx_d   = IDX_TOP;
                    div_d   = '0;
                    ref_d   = '0;
                end else begin
                    ref_d = ref_q + 1'b1;
                end
            end
            S_SHIFT_LO: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = S_SHIFT_HI;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (div_last) begin
                    div_d = '0;
                    if (idx_q == '0) begin
                        state_d = S_LATCH;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = S_SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (div_last) begin
                    div_d    = '0;
                    shadow_d = snap_q;
                    ref_d    = '0;
                    state_d  = S_IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Link outputs are registered from next-state so the external driver sees no glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            event_q    <= '0;
            hold_q     <= '0;
            led_q      <= '0;
            state_q    <= S_IDLE;
            div_q      <= '0;
            idx_q      <= '0;
            ref_q      <= '0;
            snap_q     <= '0;
            shadow_q   <= '0;
            sr_clk_q   <= 1'b0;
            sr_data_q  <= 1'b0;
            sr_latch_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            event_q    <= event_in;
            hold_q     <= hold_d;
            led_q      <= led_state;
            state_q    <= state_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            ref_q      <= ref_d;
            snap_q     <= snap_d;
            shadow_q   <= shadow_d;
            sr_clk_q   <= (state_d == S_SHIFT_HI);
            sr_data_q  <= ((state_d == S_SHIFT_LO) || (state_d == S_SHIFT_HI)) & snap_d[idx_d];
            sr_latch_q <= (state_d == S_LATCH);
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign led_out     = led_q;
    assign sr.sr_clk   = sr_clk_q;
    assign sr.sr_data  = sr_data_q;
    assign sr.sr_latch = sr_latch_q;
    assign sr.busy     = busy_q;
endmodule

// File: tb/tb_led_status_controller.sv
// Directed bench: records output traces per scenario, then decodes pulses and frames.
module tb_led_status_controller;
    localparam int MAXC = 1200;

    logic       clk = 1'b0;
    logic       rst;
    logic       lamp_test;
    logic [8:0] event_in;
    logic [8:0] led_out;

    led_sr_if sr_if ();

    led_status_controller dut (
        .clk       (clk),
        .rst       (rst),
        .event_in  (event_in),
        .lamp_test (lamp_test),
        .led_out   (led_out),
        .sr        (sr_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [8:0] l_led [MAXC];
    logic       l_clk [MAXC];
    logic       l_dat [MAXC];
    logic       l_lat [MAXC];
    logic       l_bsy [MAXC];
    int         nrec;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        event_in  = 9'h0;
        lamp_test = 1'b0;
        repeat (3) tick;
        rst = 1'b0;
    endtask

    // Sample outputs, then drive this cycle's inputs (held level plus up to two one-cycle pokes).
    task automatic rec(input int n, input logic [8:0] hold,
                       input int p0, input logic [8:0] v0,
                       input int p1, input logic [8:0] v1);
        nrec = n;
        for (int t = 0; t < n; t++) begin
            l_led[t] = led_out;
            l_clk[t] = sr_if.sr_clk;
            l_dat[t] = sr_if.sr_data;
            l_lat[t] = sr_if.sr_latch;
            l_bsy[t] = sr_if.busy;
            event_in = hold | ((t == p0) ? v0 : 9'h0) | ((t == p1) ? v1 : 9'h0);
            tick;
        end
        event_in = 9'h0;
    endtask

    task automatic width(input int ch, output int cnt, output int span);
        int first;
        int last;
        first = -1;
        last  = -1;
        cnt   = 0;
        for (int t = 0; t < nrec; t++) begin
            if (l_led[t][ch]) begin
                cnt++;
                if (first < 0) first = t;
                last = t;
            end
        end
        span = (first < 0) ? 0 : last - first + 1;
    endtask

    task automatic frame(input int k, output int start, output int blen, output logic [8:0] word,
                         output int nedge, output int lat, output int dhi, output int gapbad);
        int seen;
        int prev;
        seen = 0; prev = -1;
        start = -1; blen = 0; word = 9'h0; nedge = 0; lat = 0; dhi = 0; gapbad = 0;
        for (int t = 0; t < nrec; t++) begin
            if (l_bsy[t] && (t == 0 || !l_bsy[t-1])) begin
                seen++;
                if (seen == k) begin
                    start = t;
                    break;
                end
            end
        end
        if (start >= 0) begin
            for (int t = start; t < nrec; t++) begin
                if (!l_bsy[t]) break;
                blen++;
                if (l_clk[t] && (t == start || !l_clk[t-1])) begin
                    word = {word[7:0], l_dat[t]};
                    nedge++;
                    if (prev >= 0 && (t - prev) != 4) gapbad++;
                    prev = t;
                end
                if (l_lat[t]) lat++;
                if (l_dat[t]) dhi++;
            end
        end
    endtask

    initial begin
        int c, s, st, bl, ne, la, dh, gb;
        logic [8:0] w;

        // Reset state
        do_reset;
        chk("rst_led_out", led_out, 0);
        chk("rst_sr_clk", sr_if.sr_clk, 0);
        chk("rst_sr_data", sr_if.sr_data, 0);
        chk("rst_sr_latch", sr_if.sr_latch, 0);
        chk("rst_busy", sr_if.busy, 0);

        // Idle refresh: all-zero frame after 1024 idle cycles, only one in the window
        rec(1100, 9'h0, -1, 9'h0, -1, 9'h0);
        frame(1, st, bl, w, ne, la, dh, gb);
        chk("refresh_start", st, 1024);
        chk("refresh_word", w, 9'h000);
        chk("refresh_len", bl, 38);
        frame(2, st, bl, w, ne, la, dh, gb);
        chk("refresh_second", st, -1);

        // Single pulse on channel 0: 8-cycle LED, set frame then clearing frame
        do_reset;
        rec(120, 9'h0, 1, 9'h001, -1, 9'h0);
        width(0, c, s);
        chk("p0_width", c, 8);
        chk("p0_span", s, 8);
        frame(1, st, bl, w, ne, la, dh, gb);
        chk("p0_f1_start", st, 4);
        chk("p0_f1_word", w, 9'h001);
        chk("p0_f1_len", bl, 38);
        chk("p0_f1_data_hi", dh, 4);
        chk("p0_f1_latch", la, 2);
        frame(2, st, bl, w, ne, la, dh, gb);
        chk("p0_f2_start", st, 43);
        chk("p0_f2_word", w, 9'h000);

        // Retrigger channel 4 five cycles after first rise
        do_reset;
        rec(100, 9'h0, 0, 9'h010, 5, 9'h010);
        width(4, c, s);
        chk("retrig_width", c, 13);
        chk("retrig_span", s, 13);

        // Alternating pattern 0x155
        do_reset;
        rec(100, 9'h0, 0, 9'h155, -1, 9'h0);
        frame(1, st, bl, w, ne, la, dh, gb);
        chk("alt_start", st, 3);
        chk("alt_word", w, 9'h155);
        chk("alt_edges", ne, 9);
        chk("alt_gap", gb, 0);
        chk("alt_latch", la, 2);
        chk("alt_len", bl, 38);

        // Channel 8 change late in a frame: current frame untouched, next carries it
        do_reset;
        rec(140, 9'h0, 0, 9'h001, 33, 9'h100);
        frame(1, st, bl, w, ne, la, dh, gb);
        chk("mid_f1_word", w, 9'h001);
        chk("mid_f1_len", bl, 38);
        frame(2, st, bl, w, ne, la, dh, gb);
        chk("mid_f2_start", st, 42);
        chk("mid_f2_word", w, 9'h100);

        // Input high across reset release yields exactly one rise
        rst = 1'b1;
        event_in = 9'h002;
        repeat (2) tick;
        rst = 1'b0;
        rec(30, 9'h002, -1, 9'h0, -1, 9'h0);
        width(1, c, s);
        chk("held_width", c, 8);
        chk("held_span", s, 8);

        // Reset during SHIFT_HI of bit 5, then lamp test frame
        do_reset;
        rec(17, 9'h0, 0, 9'h001, -1, 9'h0);
        chk("abort_in_hi", sr_if.sr_clk, 1);
        chk("abort_busy", sr_if.busy, 1);
        rst = 1'b1;
        tick;
        chk("abort_led_out", led_out, 0);
        chk("abort_sr_clk", sr_if.sr_clk, 0);
        chk("abort_sr_data", sr_if.sr_data, 0);
        chk("abort_sr_latch", sr_if.sr_latch, 0);
        chk("abort_busy_low", sr_if.busy, 0);
        rst = 1'b0;
        lamp_test = 1'b1;
        rec(60, 9'h0, -1, 9'h0, -1, 9'h0);
        chk("lamp_pre_latch", l_lat[0] | l_lat[1], 0);
        frame(1, st, bl, w, ne, la, dh, gb);
        chk("lamp_start", st, 2);
        chk("lamp_word", w, 9'h1FF);
        chk("lamp_latch", la, 2);
        lamp_test = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
